// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the byte-serial data-memory initiator and its data memory.
package mem_access_unit_pkg;

    localparam int unsigned MEM_BYTES_DEFAULT = 128;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        FIN  = 2'd3
    } stateT;

    typedef enum logic {
        SIZE_HALF = 1'b0,
        SIZE_BYTE = 1'b1
    } sizeT;

    // Request attributes held for the duration of one access
    typedef struct packed {
        logic write;
        sizeT size;
        logic signExt;
    } reqCtrlT;

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Builds the 16-bit load result from the big-endian byte pair.
module mem_access_unit_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [BYTE_W-1:0] hiByte,
    input  logic [BYTE_W-1:0] loByte,
    input  sizeT              size,
    input  logic              signExt,
    output logic [DATA_W-1:0] loadData_c
);

    always_comb begin
        loadData_c = {hiByte, loByte};
        if (size == SIZE_BYTE) begin
            loadData_c = {{BYTE_W{signExt & hiByte[BYTE_W-1]}}, hiByte};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Serialises one halfword/byte load or store into big-endian byte accesses on
// the data-memory port and returns the assembled load data with a Done pulse.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Req,
    input  logic              Write,
    input  logic              ByteMode,
    input  logic              SignExt,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic              Ready,
    output logic              Done,
    output logic              Error,
    output logic [DATA_W-1:0] ReadData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [BYTE_W-1:0] MemWData,
    output logic              MemWrite,
    input  logic [BYTE_W-1:0] MemRData
);

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    stateT             state;
    stateT             stateNext;
    reqCtrlT           ctrl;
    logic [BYTE_W-1:0] loWData;
    logic [BYTE_W-1:0] hiByte;
    logic              accept_c;
    logic              inRange_c;
    logic [ADDR_W:0]   addrExt_c;
    logic [BYTE_W-1:0] alignHi_c;
    logic [DATA_W-1:0] alignData_c;

    // Range check done one bit wider so A+1 never wraps into range
    always_comb begin
        addrExt_c = {1'b0, Address};
        if (ByteMode) begin
            inRange_c = addrExt_c < MEM_LIMIT;
        end else begin
            inRange_c = (addrExt_c + (ADDR_W+1)'(1)) < MEM_LIMIT;
        end
    end

    // Next-state decode
    always_comb begin
        stateNext = state;
        accept_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (Req) begin
                    accept_c  = 1'b1;
                    stateNext = inRange_c ? HI : FIN;
                end
            end
            HI:      stateNext = (ctrl.size == SIZE_BYTE) ? FIN : LO;
            LO:      stateNext = FIN;
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // The high byte arrives from memory in the same cycle as the final edge for byte loads
    assign alignHi_c = (state == HI) ? MemRData : hiByte;

    mem_access_unit_load_align uAlign (
        .hiByte     (alignHi_c),
        .loByte     (MemRData),
        .size       (ctrl.size),
        .signExt    (ctrl.signExt),
        .loadData_c (alignData_c)
    );

    // Registered outputs and per-access context
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Ready    <= 1'b1;
            Done     <= 1'b0;
            Error    <= 1'b0;
            ReadData <= '0;
            MemAddr  <= '0;
            MemWData <= '0;
            MemWrite <= 1'b0;
            ctrl     <= '0;
            loWData  <= '0;
            hiByte   <= '0;
        end else begin
            Ready    <= (stateNext == IDLE);
            Done     <= (stateNext == FIN);
            Error    <= accept_c & ~inRange_c;
            MemWrite <= 1'b0;
            if (accept_c) begin
                ctrl.write   <= Write;
                ctrl.size    <= sizeT'(ByteMode);
                ctrl.signExt <= SignExt;
                loWData      <= WriteData[BYTE_W-1:0];
                if (inRange_c) begin
                    MemAddr  <= Address;
                    MemWData <= ByteMode ? WriteData[BYTE_W-1:0] : WriteData[DATA_W-1:BYTE_W];
                    MemWrite <= Write;
                end
            end
            if (state == HI) begin
                hiByte <= MemRData;
                if (ctrl.size == SIZE_HALF) begin
                    MemAddr  <= MemAddr + ADDR_W'(1);
                    MemWData <= loWData;
                    MemWrite <= ctrl.write;
                end
            end
            if ((stateNext == FIN) && ((state == HI) || (state == LO)) && !ctrl.write) begin
                ReadData <= alignData_c;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a 128-byte behavioural data memory.
module tb_mem_access_unit;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Req;
    logic        Write;
    logic        ByteMode;
    logic        SignExt;
    logic [15:0] Address;
    logic [15:0] WriteData;
    logic        Ready;
    logic        Done;
    logic        Error;
    logic [15:0] ReadData;
    logic [15:0] MemAddr;
    logic [7:0]  MemWData;
    logic        MemWrite;
    logic [7:0]  MemRData;

    typedef struct {
        logic [15:0] rd;
        logic        err;
        int          lat;
        int          acc;
    } doneT;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wrT;

    doneT doneQ[$];
    wrT   wrQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lastDone = -100;
    logic memLoad;
    logic [7:0] mem [128];

    mem_access_unit dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Req       (Req),
        .Write     (Write),
        .ByteMode  (ByteMode),
        .SignExt   (SignExt),
        .Address   (Address),
        .WriteData (WriteData),
        .Ready     (Ready),
        .Done      (Done),
        .Error     (Error),
        .ReadData  (ReadData),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .MemWrite  (MemWrite),
        .MemRData  (MemRData)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [7:0] initByte(input int i);
        if (i == 5) return 8'h9C;
        if (i == 6) return 8'h5A;
        return 8'(i) ^ 8'hA5;
    endfunction

    always @(posedge Clock) begin
        if (memLoad) begin
            for (int i = 0; i < 128; i++) mem[i] <= initByte(i);
        end else if (MemWrite && (MemAddr < 16'd128)) begin
            mem[MemAddr[6:0]] <= MemWData;
        end
    end

    assign MemRData = (MemAddr < 16'd128) ? mem[MemAddr[6:0]] : 8'h00;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endfunction

    // Monitor: memory write cycles and Done pulses against the queued expectations
    always @(negedge Clock) begin
        wrT   w;
        doneT d;
        if (Reset_n && !memLoad) begin
            if (MemWrite) begin
                if (wrQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write got addr=%h data=%h exp=none", MemAddr, MemWData);
                end else begin
                    w = wrQ.pop_front();
                    chk("wr_addr", 32'(MemAddr), 32'(w.addr));
                    chk("wr_data", 32'(MemWData), 32'(w.data));
                end
            end
            if (Done) begin
                lastDone = cyc;
                if (doneQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got rd=%h err=%b exp=none", ReadData, Error);
                end else begin
                    d = doneQ.pop_front();
                    chk("read_data", 32'(ReadData), 32'(d.rd));
                    chk("error", 32'(Error), 32'(d.err));
                    chk("latency", cyc - d.acc, d.lat);
                end
            end
        end
    end

    // Present a request, wait for acceptance, then queue its expected effects
    task automatic issue(input logic wr, input logic bm, input logic se,
                         input logic [15:0] addr, input logic [15:0] wd,
                         input logic keepReq, input logic b2b, input logic expDone,
                         input logic [15:0] expRd, input logic expErr, input int expLat,
                         input int nWr, input logic [15:0] w0a, input logic [7:0] w0d,
                         input logic [15:0] w1a, input logic [7:0] w1d);
        int   a;
        doneT d;
        wrT   w;
        @(negedge Clock);
        Req = 1'b1; Write = wr; ByteMode = bm; SignExt = se; Address = addr; WriteData = wd;
        for (int i = 0; i < 50 && !Ready; i++) @(negedge Clock);
        if (!Ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got Ready=%b exp=1", Ready);
            Req = 1'b0;
            return;
        end
        a = cyc;
        if (b2b) chk("b2b_accept", a, lastDone + 1);
        @(posedge Clock);
        #1;
        if (nWr > 0) begin w.addr = w0a; w.data = w0d; wrQ.push_back(w); end
        if (nWr > 1) begin w.addr = w1a; w.data = w1d; wrQ.push_back(w); end
        if (expDone) begin
            d.rd = expRd; d.err = expErr; d.lat = expLat; d.acc = a;
            doneQ.push_back(d);
        end
        if (!keepReq) Req = 1'b0;
        Write = ~wr;
        Address = 16'h0040;
        WriteData = 16'hDEAD;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 100 && (doneQ.size() != 0 || wrQ.size() != 0); i++) @(negedge Clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Req = 0; Write = 0; ByteMode = 0; SignExt = 0; Address = 0; WriteData = 0;
        Reset_n = 0; memLoad = 1;
        repeat (3) @(negedge Clock);
        chk("rst_ready", 32'(Ready), 1);
        chk("rst_done", 32'(Done), 0);
        chk("rst_error", 32'(Error), 0);
        chk("rst_rdata", 32'(ReadData), 0);
        chk("rst_memaddr", 32'(MemAddr), 0);
        chk("rst_memwdata", 32'(MemWData), 0);
        chk("rst_memwrite", 32'(MemWrite), 0);
        memLoad = 0;
        @(negedge Clock);
        Reset_n = 1;

        //    wr bm se addr      wd        keep b2b done rd        err lat n  w0a    w0d    w1a    w1d
        issue(1, 0, 0, 16'd2,    16'h1234, 0,   0,  1,   16'h0000, 0,  3,  2, 16'd2, 8'h12, 16'd3, 8'h34);
        issue(0, 0, 0, 16'd2,    16'h0000, 0,   0,  1,   16'h1234, 0,  3,  0, 16'd0, 8'h00, 16'd0, 8'h00);
        issue(0, 1, 1, 16'd5,    16'h0000, 0,   0,  1,   16'hFF9C, 0,  2,  0, 16'd0, 8'h00, 16'd0, 8'h00);
        issue(0, 1, 0, 16'd5,    16'h0000, 0,   0,  1,   16'h009C, 0,  2,  0, 16'd0, 8'h00, 16'd0, 8'h00);
        issue(1, 1, 0, 16'd7,    16'hABCD, 0,   0,  1,   16'h009C, 0,  2,  1, 16'd7, 8'hCD, 16'd0, 8'h00);
        issue(0, 0, 0, 16'd6,    16'h0000, 0,   0,  1,   16'h5ACD, 0,  3,  0, 16'd0, 8'h00, 16'd0, 8'h00);
        issue(0, 0, 0, 16'd127,  16'h0000, 0,   0,  1,   16'h5ACD, 1,  1,  0, 16'd0, 8'h00, 16'd0, 8'h00);
        issue(1, 0, 0, 16'hFFFF, 16'h1111, 0,   0,  1,   16'h5ACD, 1,  1,  0, 16'd0, 8'h00, 16'd0, 8'h00);
        issue(0, 1, 1, 16'd127,  16'h0000, 0,   0,  1,   16'hFFDA, 0,  2,  0, 16'd0, 8'h00, 16'd0, 8'h00);
        issue(0, 1, 0, 16'd128,  16'h0000, 0,   0,  1,   16'hFFDA, 1,  1,  0, 16'd0, 8'h00, 16'd0, 8'h00);
        waitIdle();

        // Req held across a store, then a second request taken right after Done
        issue(1, 0, 0, 16'd30,   16'hBEEF, 1,   0,  1,   16'hFFDA, 0,  3,  2, 16'd30, 8'hBE, 16'd31, 8'hEF);
        issue(0, 0, 0, 16'd30,   16'h0000, 0,   1,  1,   16'hBEEF, 0,  3,  0, 16'd0, 8'h00, 16'd0, 8'h00);
        // Store pulse while busy must be dropped
        @(negedge Clock);
        Req = 1; Write = 1; ByteMode = 1; Address = 16'd10; WriteData = 16'hFFFF;
        @(negedge Clock);
        Req = 0;
        waitIdle();
        issue(0, 1, 1, 16'd31,   16'h0000, 0,   0,  1,   16'hFFEF, 0,  2,  0, 16'd0, 8'h00, 16'd0, 8'h00);
        waitIdle();

        // Reset in the low-byte cycle of a store
        issue(1, 0, 0, 16'd20,   16'h55AA, 0,   0,  0,   16'h0000, 0,  0,  1, 16'd20, 8'h55, 16'd0, 8'h00);
        @(posedge Clock);
        #1;
        chk("lo_memwrite", 32'(MemWrite), 1);
        chk("lo_memaddr", 32'(MemAddr), 21);
        #1;
        Reset_n = 0;
        #1;
        chk("async_memwrite", 32'(MemWrite), 0);
        chk("async_ready", 32'(Ready), 1);
        repeat (2) @(negedge Clock);
        Reset_n = 1;
        #1;
        chk("post_rst_ready", 32'(Ready), 1);
        chk("post_rst_done", 32'(Done), 0);
        chk("post_rst_rdata", 32'(ReadData), 0);
        issue(0, 0, 0, 16'd20,   16'h0000, 0,   0,  1,   16'h55B0, 0,  3,  0, 16'd0, 8'h00, 16'd0, 8'h00);
        waitIdle();
        repeat (3) @(negedge Clock);

        chk("done_queue_empty", doneQ.size(), 0);
        chk("write_queue_empty", wrQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the CPU's byte-wide big-endian data memory.
- Accepts one halfword or byte load/store request from the CPU datapath and serialises it into per-byte accesses on the memory port: high byte at Address, low byte at Address+1.
- Returns assembled read data with a one-cycle Done pulse.
- Sits between the execute stage and the data memory; it is the only driver of the memory's address, write-data and write-enable.

Parameters:
- ADDR_W, 16, address width on both sides.
- MEM_BYTES, 128, implemented memory size in bytes; byte addresses >= MEM_BYTES are out of range.

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Reset_n  input  1  asynchronous, active-low reset.
- Req  input  1  CPU request; sampled only while Ready=1.
- Write  input  1  1=store, 0=load; latched on accept.
- ByteMode  input  1  1=byte access, 0=halfword; latched on accept.
- SignExt  input  1  byte loads only: 1=sign-extend, 0=zero-extend; latched on accept.
- Address  input  ADDR_W  byte address of the access; latched on accept.
- WriteData  input  16  store data; latched on accept.
- Ready  output  1  unit idle; a request is accepted this cycle if Req=1.
- Done  output  1  one-cycle pulse; access complete.
- Error  output  1  valid with Done; access was out of range and was suppressed.
- ReadData  output  16  load result; valid from Done, held until the next accept.
- MemAddr  output  ADDR_W  byte address to data memory.
- MemWData  output  8  byte to write.
- MemWrite  output  1  byte write enable; memory writes on posedge.
- MemRData  input  8  combinational read byte at MemAddr.

Behaviour:
- Reset (async, Reset_n=0): state IDLE; Ready=1, Done=0, Error=0, ReadData=0, MemAddr=0, MemWData=0, MemWrite=0.
- MemWrite and MemAddr are decoded from registered state only, so reset drops MemWrite asynchronously.
- Reset mid-store may leave only the high byte written; this is accepted behaviour and must not hang.
- States are IDLE, HI, LO, FIN.
- IDLE:
  - Ready=1.
  - On posedge with Req=1: latch Write, ByteMode, SignExt, Address (A) and WriteData (WD).
  - Range check: halfword requires A < MEM_BYTES and A+1 < MEM_BYTES; byte requires A < MEM_BYTES.
  - In range -> HI. Out of range -> FIN with Error latched and no memory cycle.
  - Req=0: stay.
- HI:
  - MemAddr=A.
  - Halfword: MemWData=WD[15:8]. Byte: MemWData=WD[7:0].
  - MemWrite=Write.
  - On posedge, capture MemRData into hi_byte.
  - Next state: halfword -> LO; byte -> FIN.
- LO (halfword only):
  - MemAddr=A+1, truncated to ADDR_W, so 16'hFFFF+1 = 16'h0000. This case is already out of range when MEM_BYTES < 65536.
  - MemWData=WD[7:0], MemWrite=Write.
  - On posedge, capture MemRData into lo_byte; -> FIN.
- FIN:
  - Done=1 for exactly this cycle; Error as latched; Ready=0.
  - ReadData for a load with no error:
    - halfword: {hi_byte, lo_byte}
    - byte with SignExt=1: {8{hi_byte[7]}, hi_byte}
    - byte with SignExt=0: {8'h00, hi_byte}
  - Store or error: ReadData unchanged.
  - Next state: -> IDLE.
- Latency from the accept edge to Done high: halfword 3 cycles, byte 2 cycles, error 1 cycle.
- Back-to-back throughput: one access per latency+1 cycles.
- Outside HI/LO: MemWrite=0 and MemAddr holds its last value (no glitches).
- Requests presented while Ready=0 are ignored, not queued. The requester holds Req until it sees Ready.
- Inputs changing after accept have no effect.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE/HI/LO/FIN, 2-bit);
  - the access-size constants (SIZE_BYTE/SIZE_HALF);
  - MEM_BYTES default, shared with the data memory.
- One natural sub-module: load_align.
  - Combinational.
  - Takes hi_byte, lo_byte, ByteMode and SignExt; produces the 16-bit load result.
  - Reused later by the I/O path.

Test Plan:
- Halfword store A=2, WD=16'h1234, then halfword load A=2:
  - store: MemWrite high 2 cycles with (2, 8'h12) then (3, 8'h34); Done 3 cycles after accept, Error=0;
  - load: ReadData=16'h1234 at Done.
- Byte load from A=5 holding 8'h9C:
  - SignExt=1 -> 16'hFF9C;
  - SignExt=0 -> 16'h009C;
  - Done 2 cycles after accept.
- Byte store A=7, WD=16'hABCD:
  - exactly one MemWrite cycle, at address 7 with data 8'hCD;
  - a following halfword load at A=6 returns {old byte 6, 8'hCD}.
- Out-of-range accesses:
  - halfword A=127 (MEM_BYTES=128) -> Done+Error after 1 cycle, MemWrite never asserted;
  - A=16'hFFFF halfword -> Error, with no access at 0.
- Protocol: Req held high across a store; second request with new Address accepted only on the cycle after Done; Req pulsed while Ready=0 is ignored.
- Reset_n low in state LO of a store -> MemWrite falls without waiting for a clock; after release Ready=1, Done=0, ReadData=0; the next load completes normally.
